// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: turns PS/2 scan-code set 2 bytes into key events in a FIFO.
// Ports: clk, rst (async, active-high); byte_valid/byte_data are the scan byte strobe.
//   ev_valid/ev_data/ev_ready form the event FIFO head handshake.
//   ev_data = {ext, brk, shift, ctrl, code[7:0]}. fifo_level is the number of held entries.
//   shift/ctrl/caps give the modifier state. press_cnt counts emitted makes.
//   overflow is sticky and means an event was dropped.
// Optional feature: define KEY_REPEAT_FILTER_EN to suppress typematic repeat makes.
module ps2_key_event_decoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [11:0]              ev_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     shift,
  output logic                     ctrl,
  output logic                     caps,
  output logic [CNT_W-1:0]         press_cnt,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
  state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic lshift_q, lshift_d, rshift_q, rshift_d, lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic caps_q, caps_d, overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic [11:0] mem_q [DEPTH];
  logic [11:0] mem_d [DEPTH];
  logic emit, ev_ext, ev_brk, ignore, repeat_hit, go, make_go, full, pop, push;
  assign ignore = byte_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (byte_valid)
      case (state_q)
        IDLE: begin
          if (byte_data == 8'hE0) state_d = EXT;
          else if (byte_data == 8'hF0) state_d = BRK;
          else if (byte_data == 8'hE1) begin
            state_d = PAUSE;
            skip_d  = 3'd7;
          end else emit = !ignore;
        end
        EXT: begin
          ev_ext  = 1'b1;
          state_d = byte_data == 8'hF0 ? EXT_BRK : IDLE;
          emit    = !(byte_data inside {8'hF0, 8'hE0, 8'hE1});
        end
        BRK: begin
          emit    = 1'b1;
          ev_brk  = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          emit    = 1'b1;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
          state_d = IDLE;
        end
        PAUSE: begin
          skip_d  = skip_q - 3'd1;
          state_d = skip_q == 3'd1 ? IDLE : PAUSE;
        end
        default: state_d = IDLE;
      endcase
  end
`ifdef KEY_REPEAT_FILTER_EN
  logic [8:0] last_q, last_d;
  logic last_vld_q, last_vld_d;
  assign repeat_hit = emit && !ev_brk && last_vld_q && last_q == {ev_ext, byte_data};
  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (emit && !ev_brk) begin
      last_d     = {ev_ext, byte_data};
      last_vld_d = 1'b1;
    end else if (emit && last_q == {ev_ext, byte_data}) last_vld_d = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
`else
  assign repeat_hit = 1'b0;
`endif
  assign go      = emit && !repeat_hit;
  assign make_go = go && !ev_brk;
  assign full    = level_q == (AW+1)'(DEPTH);
  assign pop     = ev_valid && ev_ready;
  assign push    = go && (!full || pop);
  // Modifier bits are idempotent, so a filtered repeat may still drive them.
  always_comb begin
    lshift_d   = emit && !ev_ext && byte_data == 8'h12 ? !ev_brk : lshift_q;
    rshift_d   = emit && !ev_ext && byte_data == 8'h59 ? !ev_brk : rshift_q;
    lctrl_d    = emit && !ev_ext && byte_data == 8'h14 ? !ev_brk : lctrl_q;
    rctrl_d    = emit && ev_ext && byte_data == 8'h14 ? !ev_brk : rctrl_q;
    caps_d     = caps_q ^ (make_go && !ev_ext && byte_data == 8'h58);
    cnt_d      = cnt_q + CNT_W'(make_go);
    overflow_d = overflow_q || (go && full && !pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
    mem_d      = mem_q;
    if (push) mem_d[wr_q] = {ev_ext, ev_brk, shift, ctrl, byte_data};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      skip_q     <= '0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      lctrl_q    <= 1'b0;
      rctrl_q    <= 1'b0;
      caps_q     <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      lctrl_q    <= lctrl_d;
      rctrl_q    <= rctrl_d;
      caps_q     <= caps_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      mem_q      <= mem_d;
    end
  assign shift      = lshift_q || rshift_q;
  assign ctrl       = lctrl_q || rctrl_q;
  assign caps       = caps_q;
  assign press_cnt  = cnt_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;
  assign ev_valid   = level_q != '0;
  assign ev_data    = mem_q[rd_q];
endmodule
